// File: rtl/req_ack_responder.sv
`default_nettype none
// ============================================================================
// Module      : req_ack_responder
// Description : Responder end of a 4-phase req/ack handshake. It acks after a
//               per-request latency and returns req_data+1. It also flags
//               early req drops and counts completed transactions.
//               Optional macro RESP_ASSERT_EN compiles in protocol SVA.
// Revision    : 1.0 - initial release
// ============================================================================
module req_ack_responder #(
  parameter int DATA_W = 8,
  parameter int LAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  input  logic [LAT_W-1:0]  lat,
  output logic              ack,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              proto_err,
  output logic [CNT_W-1:0]  txn_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            r_state;
  logic [LAT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      ack       <= 1'b0;
      rsp_data  <= '0;
      proto_err <= 1'b0;
      txn_cnt   <= '0;
    end else begin
      proto_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_data  <= req_data;
            r_cnt   <= lat;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Initiator abandoned the request before we answered it
          if (!req) begin
            proto_err <= 1'b1;
            r_state   <= S_IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - LAT_W'(1);
          end else begin
            ack      <= 1'b1;
            rsp_data <= r_data + DATA_W'(1);
            r_state  <= S_ACK;
          end
        end
        S_ACK: begin
          if (!req) begin
            ack     <= 1'b0;
            txn_cnt <= txn_cnt + CNT_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RESP_ASSERT_EN
  a_ack_after_req: assert property (@(posedge clk) disable iff (rst)
    $rose(ack) |-> $past(req))
    else $error("ack rose without prior req at %0t", $time);

  a_ack_hold: assert property (@(posedge clk) disable iff (rst)
    (ack && req) |=> ack)
    else $error("ack dropped while req high at %0t", $time);

  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    ack |=> (!ack || $stable(rsp_data)))
    else $error("rsp_data changed while ack high at %0t", $time);

  a_err_pulse: assert property (@(posedge clk) disable iff (rst)
    proto_err |=> !proto_err)
    else $error("proto_err high two cycles at %0t", $time);
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_ack_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_ack_responder
// Description : Directed self-checking bench for req_ack_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_ack_responder;

  localparam int DATA_W = 8;
  localparam int LAT_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              req;
  logic [DATA_W-1:0] req_data;
  logic [LAT_W-1:0]  lat;
  logic              ack;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              proto_err;
  logic [CNT_W-1:0]  txn_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  req_ack_responder #(
    .DATA_W(DATA_W),
    .LAT_W (LAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .lat      (lat),
    .ack      (ack),
    .rsp_data (rsp_data),
    .busy     (busy),
    .proto_err(proto_err),
    .txn_cnt  (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = 1'b1;
    lat      = 4'd3;
    req_data = 8'h10;

    // 1: reset held with req high, then lat=3 request
    #20;
    chk("rst_ack",   32'(ack),       32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_txn",   32'(txn_cnt),   32'd0);
    chk("rst_perr",  32'(proto_err), 32'd0);
    chk("rst_rsp",   32'(rsp_data),  32'd0);
    #30;
    rst = 1'b0;
    tick();
    chk("t1_accept_busy", 32'(busy), 32'd1);
    chk("t1_accept_ack",  32'(ack),  32'd0);
    tick(); tick(); tick();
    chk("t1_e3_ack", 32'(ack), 32'd0);
    tick();
    chk("t1_e4_ack", 32'(ack),      32'd1);
    chk("t1_rsp",    32'(rsp_data), 32'h11);
    req_data = 8'h55;
    lat      = 4'd0;
    tick();
    chk("t1_hold_ack", 32'(ack),      32'd1);
    chk("t1_hold_rsp", 32'(rsp_data), 32'h11);
    req = 1'b0;
    tick();
    chk("t1_done_ack",  32'(ack),     32'd0);
    chk("t1_done_busy", 32'(busy),    32'd0);
    chk("t1_done_txn",  32'(txn_cnt), 32'd1);

    // 2: lat=0, FE -> FF
    req_data = 8'hFE;
    lat      = 4'd0;
    req      = 1'b1;
    tick();
    chk("t2_e0_ack", 32'(ack), 32'd0);
    tick();
    chk("t2_e1_ack", 32'(ack),      32'd1);
    chk("t2_rsp",    32'(rsp_data), 32'hFF);
    req = 1'b0;
    tick();
    chk("t2_ack_fall", 32'(ack),     32'd0);
    chk("t2_txn",      32'(txn_cnt), 32'd2);

    // 3: FF wraps to 00
    req_data = 8'hFF;
    req      = 1'b1;
    tick(); tick();
    chk("t3_ack", 32'(ack),      32'd1);
    chk("t3_rsp", 32'(rsp_data), 32'h00);
    req = 1'b0;
    tick();
    chk("t3_txn", 32'(txn_cnt), 32'd3);

    // 4: early drop during WAIT
    lat      = 4'd5;
    req_data = 8'h20;
    req      = 1'b1;
    tick(); tick(); tick();
    req = 1'b0;
    tick();
    chk("t4_perr",  32'(proto_err), 32'd1);
    chk("t4_ack",   32'(ack),       32'd0);
    chk("t4_busy",  32'(busy),      32'd0);
    chk("t4_txn",   32'(txn_cnt),   32'd3);
    tick();
    chk("t4_perr_pulse", 32'(proto_err), 32'd0);
    chk("t4_ack2",       32'(ack),       32'd0);

    // 5: async reset while ack high, req kept high across release
    lat      = 4'd0;
    req_data = 8'h30;
    req      = 1'b1;
    tick(); tick();
    chk("t5_ack_pre", 32'(ack), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_ack",  32'(ack),       32'd0);
    chk("t5_async_perr", 32'(proto_err), 32'd0);
    chk("t5_async_txn",  32'(txn_cnt),   32'd0);
    chk("t5_async_busy", 32'(busy),      32'd0);
    tick();
    chk("t5_inrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("t5_reaccept_busy", 32'(busy), 32'd1);
    tick();
    chk("t5_reaccept_ack", 32'(ack),      32'd1);
    chk("t5_reaccept_rsp", 32'(rsp_data), 32'h31);
    req = 1'b0;
    tick();
    chk("t5_txn", 32'(txn_cnt), 32'd1);

    // 6: 16 back-to-back lat=1 transactions from a clean reset
    #2;
    rst = 1'b1;
    #4;
    rst = 1'b0;
    tick();
    chk("t6_txn0", 32'(txn_cnt), 32'd0);
    lat = 4'd1;
    for (int i = 0; i < 16; i++) begin
      req_data = 8'(i * 3);
      req      = 1'b1;
      tick(); tick(); tick();
      chk("t6_ack", 32'(ack),      32'd1);
      chk("t6_rsp", 32'(rsp_data), 32'((i * 3 + 1) % 256));
      req = 1'b0;
      tick();
      chk("t6_txn", 32'(txn_cnt), 32'((i + 1) % 16));
      chk("t6_perr", 32'(proto_err), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
